except_ctrl: RTL and testbench
==============================

EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  N_HW_INT, 6, hardware interrupt lines used, legal range 1..6.
  N_SRC, 8, synchronous exception sources; index 0 has highest priority.
  SRC_CODES, {8{5'h00}} packed N_SRC*5 bits, ExcCode for each source; slice i belongs to source i.
  EXCEPT_PC, 32'hBFC00380, common exception entry address.
  FLUSH_CYC, 1, flush pulse length in cycles, legal range 1..15.
  SYNC_STAGES, 2, synchronizer depth on ext_int, legal range 2..3.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  clock, all state on the rising edge.
  rst  in  1  asynchronous, active-low reset.
  ext_int  in  N_HW_INT  asynchronous hardware interrupt lines.
  cp0_status  in  32  CP0 Status register.
  cp0_cause  in  32  CP0 Cause register; bits 9:8 are the software interrupts.
  cp0_epc  in  32  CP0 EPC register.
  instr_validM  in  1  M stage holds a real instruction.
  pcM  in  32  M-stage PC.
  is_in_delayslotM  in  1  M instruction sits in a branch delay slot.
  src_vecM  in  N_SRC  synchronous exception flags.
  is_eretM  in  1  ERET in M.
  redirect_ready  in  1  fetch accepts the redirect.
  busy  out  1  controller is not idle; upstream stalls.
  flush  out  1  pipeline flush.
  except_valid  out  1  redirect request.
  except_type  out  32  exception code.
  except_pc  out  32  redirect target.
  epc_we  out  1  CP0 EPC/Cause write strobe.
  epc_data  out  32  EPC value to write.
  cause_bd  out  1  BD bit to write.

Function
REQ-003 Synchronizer: ext_int SHALL pass through SYNC_STAGES flops to give int_sync.
REQ-004 Interrupt vector: int_sync SHALL be zero-extended to 6 bits and form {int_sync6, cp0_cause[9:8]}.
REQ-005 int_req SHALL be high when all of these hold: (cp0_status[15:8] & vector) != 0, cp0_status[1]==0 (EXL), cp0_status[0]==1 (IE).
REQ-006 Event condition: an event SHALL exist only while state==IDLE and instr_validM==1, and at least one of int_req, any src_vecM bit, or is_eretM is high.
REQ-007 Priority SHALL be int_req, then src_vecM[0], through src_vecM[N_SRC-1], then is_eretM; only the winner is captured.
REQ-008 Captured code SHALL be 32'h0 for an interrupt, {27'b0, SRC_CODES[5i+4:5i]} for source i, and 32'h0000000e for ERET.
REQ-009 Captured target SHALL be EXCEPT_PC, except cp0_epc sampled at the capture edge for ERET.
REQ-010 Captured EPC SHALL be pcM-4 when is_in_delayslotM==1, otherwise pcM; arithmetic is modulo 2^32.
REQ-011 FSM SHALL have states IDLE, FLUSH, REDIRECT.
REQ-012 IDLE SHALL move to FLUSH on the edge that samples an event and load the capture registers.
REQ-013 FLUSH SHALL drive flush=1 for exactly FLUSH_CYC cycles using a 4-bit down-counter, then move to REDIRECT.
REQ-014 epc_we SHALL be 1 only in the first FLUSH cycle and only for non-ERET events; epc_data and cause_bd SHALL be valid in that cycle.
REQ-015 REDIRECT SHALL hold except_valid=1 with except_type and except_pc stable until redirect_ready is sampled high, then move to IDLE.
REQ-016 Zero-wait handshake: when redirect_ready is already high on entry to REDIRECT, except_valid SHALL last exactly 1 cycle.
REQ-017 busy SHALL be 1 whenever state!=IDLE.
REQ-018 Events arriving while busy SHALL be ignored and SHALL NOT be queued; the stalled pipeline re-presents them.
REQ-019 Outside REDIRECT, except_type SHALL be 32'hffffffff and except_pc SHALL be 0.
REQ-020 Event latency SHALL be: flush starts 1 cycle after the sampling edge, and except_valid rises FLUSH_CYC+1 cycles after it.

Reset
REQ-021 When rst==0, the block SHALL asynchronously force state=IDLE, clear the counter, capture registers and synchronizer, and drive busy=flush=except_valid=epc_we=cause_bd=0, except_pc=0, epc_data=0 and except_type=32'hffffffff.
REQ-022 Reset asserted mid-FLUSH or mid-REDIRECT SHALL abandon the event with no residual strobe after release.
REQ-023 The first event SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-024 Interrupt path: status=32'h0000_0401, ext_int[0] held high, instr_validM=1, pcM=32'h8000_0100 -> after SYNC_STAGES+1 edges, flush=1 for 1 cycle with epc_we=1, epc_data=32'h8000_0100; then except_valid=1, type=0, pc=32'hBFC00380.
REQ-025 Simultaneous events: src_vecM[0]=1 and src_vecM[3]=1 with is_eretM=1, delay slot set, pcM=32'h8000_0008, SRC_CODES slice0=5'h04 -> type=32'h4, epc_data=32'h8000_0004, cause_bd=1.
REQ-026 ERET: is_eretM=1, cp0_epc=32'h8000_1234 -> epc_we stays 0; except_pc=32'h8000_1234, except_type=32'he.
REQ-027 Handshake backpressure: redirect_ready low for 5 cycles -> except_valid held for 6 cycles with outputs stable; a new src event during that window is ignored.
REQ-028 Mid-operation reset: FLUSH_CYC=3, rst pulsed low in the 2nd flush cycle -> all outputs reach reset values immediately; no except_valid follows.
REQ-029 EXL masking: status[1]=1 with an interrupt pending -> no event and busy stays 0.

Source files
------------

// File: rtl/except_ctrl.sv
// -----------------------------------------------------------------------------
// except_ctrl -- exception / interrupt / ERET sequencing controller.
//
// Watches the M stage for a hardware interrupt, a synchronous exception or an
// ERET. It captures the highest-priority one, flushes the pipeline for
// FLUSH_CYC cycles, and then holds a redirect request until fetch accepts it.
// While the controller is not idle, new events are dropped. The stalled
// pipeline presents them again later.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   ext_int           asynchronous hardware interrupt lines
//   cp0_status/cause/epc  CP0 Status, Cause (bits 9:8 = soft ints), EPC
//   instr_validM, pcM, is_in_delayslotM, src_vecM, is_eretM   M-stage info
//   redirect_ready    fetch accepts the redirect
//   busy, flush       controller not idle / pipeline flush
//   except_valid, except_type, except_pc   redirect request, code, target
//   epc_we, epc_data, cause_bd             CP0 EPC/Cause update
// -----------------------------------------------------------------------------
module except_ctrl #(
  parameter int                 N_HW_INT    = 6,
  parameter int                 N_SRC       = 8,
  parameter logic [N_SRC*5-1:0] SRC_CODES   = {N_SRC{5'h00}},
  parameter logic [31:0]        EXCEPT_PC   = 32'hBFC00380,
  parameter int                 FLUSH_CYC   = 1,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_HW_INT-1:0] ext_int,
  input  logic [31:0]         cp0_status,
  input  logic [31:0]         cp0_cause,
  input  logic [31:0]         cp0_epc,
  input  logic                instr_validM,
  input  logic [31:0]         pcM,
  input  logic                is_in_delayslotM,
  input  logic [N_SRC-1:0]    src_vecM,
  input  logic                is_eretM,
  input  logic                redirect_ready,
  output logic                busy,
  output logic                flush,
  output logic                except_valid,
  output logic [31:0]         except_type,
  output logic [31:0]         except_pc,
  output logic                epc_we,
  output logic [31:0]         epc_data,
  output logic                cause_bd
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] FLUSH_LEN = 4'(FLUSH_CYC);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // ext_int synchronizer
  // ---------------------------------------------------------------------------
  logic [N_HW_INT-1:0] sync_q [SYNC_STAGES];

  // NOTE: every stage is reset. A stale high left in the chain would raise a
  // spurious interrupt right after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Event detection and priority selection
  // ---------------------------------------------------------------------------
  logic [5:0]  int_sync6;
  logic [7:0]  irq_vec;
  logic        int_req;
  logic        src_any;
  logic        event_hit;
  logic [31:0] win_type;
  logic [31:0] win_pc;
  logic        win_eret;

  // NOTE: each always_comb assigns defaults first. No path can leave a
  // signal unassigned, so no latch is inferred.
  always_comb begin
    int_sync6                 = '0;
    int_sync6[N_HW_INT-1:0]   = sync_q[SYNC_STAGES-1];
  end

  assign irq_vec   = {int_sync6, cp0_cause[9:8]};
  // Masked by IM, blocked while EXL is set, and gated by the global IE.
  assign int_req   = (|(cp0_status[15:8] & irq_vec)) & ~cp0_status[1] & cp0_status[0];
  assign src_any   = |src_vecM;
  assign event_hit = (state_q == IDLE) && instr_validM && (int_req || src_any || is_eretM);

  always_comb begin
    win_type = 32'h0;
    win_pc   = EXCEPT_PC;
    win_eret = 1'b0;
    if (int_req) begin
      win_type = 32'h0;
    end else if (src_any) begin
      // Scan downward so the lowest set index (highest priority) wins.
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (src_vecM[i]) win_type = {27'b0, SRC_CODES[5*i +: 5]};
      end
    end else begin
      win_type = 32'h0000_000e;
      win_pc   = cp0_epc;
      win_eret = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture registers
  // ---------------------------------------------------------------------------
  logic [31:0] cap_type, cap_pc, cap_epc;
  logic        cap_bd, cap_eret;

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // sees the pre-edge values of the others, whatever the order of the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_type <= '0;
      cap_pc   <= '0;
      cap_epc  <= '0;
      cap_bd   <= 1'b0;
      cap_eret <= 1'b0;
    end else if (event_hit) begin
      cap_type <= win_type;
      cap_pc   <= win_pc;
      cap_epc  <= is_in_delayslotM ? (pcM - 32'd4) : pcM;
      cap_bd   <= is_in_delayslotM;
      cap_eret <= win_eret;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register + flush down-counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode directly from state, so an asynchronous reset forces them
  // to their idle values immediately.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy         = (state_q != IDLE);
    flush        = 1'b0;
    except_valid = 1'b0;
    except_type  = 32'hffff_ffff;
    except_pc    = 32'h0;
    epc_we       = 1'b0;
    epc_data     = 32'h0;
    cause_bd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (event_hit) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LEN;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        // The counter still holds its load value only in the first flush cycle.
        if (cnt_q == FLUSH_LEN && !cap_eret) begin
          epc_we   = 1'b1;
          epc_data = cap_epc;
          cause_bd = cap_bd;
        end
        if (cnt_q <= 4'd1) begin
          state_d = REDIRECT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        except_valid = 1'b1;
        except_type  = cap_type;
        except_pc    = cap_pc;
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_except_ctrl.sv
// -----------------------------------------------------------------------------
// tb_except_ctrl -- self-checking bench for except_ctrl.
//
// dut  : FLUSH_CYC=1. Every output is checked on every cycle against a timeline
//        model (event edge + cycle offsets).
// dut3 : FLUSH_CYC=3. It shares all inputs. Directed checks cover the multi-cycle
//        flush and the mid-flush reset.
// -----------------------------------------------------------------------------
module tb_except_ctrl;

  localparam logic [39:0] CODES = {5'h0d, 5'h0c, 5'h0b, 5'h0a, 5'h08, 5'h06, 5'h05, 5'h04};
  localparam int          FC    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ext_int;
  logic [31:0] cp0_status, cp0_cause, cp0_epc, pcM;
  logic        instr_validM, is_in_delayslotM, is_eretM, redirect_ready;
  logic [7:0]  src_vecM;

  logic        busy, flush, except_valid, epc_we, cause_bd;
  logic [31:0] except_type, except_pc, epc_data;
  logic        b3_busy, b3_flush, b3_valid, b3_epc_we, b3_bd;
  logic [31:0] b3_type, b3_pc, b3_epc_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  except_ctrl #(.N_HW_INT(6), .N_SRC(8), .SRC_CODES(CODES), .EXCEPT_PC(32'hBFC00380),
                .FLUSH_CYC(FC), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ext_int(ext_int), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .instr_validM(instr_validM), .pcM(pcM),
    .is_in_delayslotM(is_in_delayslotM), .src_vecM(src_vecM), .is_eretM(is_eretM),
    .redirect_ready(redirect_ready), .busy(busy), .flush(flush),
    .except_valid(except_valid), .except_type(except_type), .except_pc(except_pc),
    .epc_we(epc_we), .epc_data(epc_data), .cause_bd(cause_bd));

  except_ctrl #(.N_HW_INT(6), .N_SRC(8), .SRC_CODES(CODES), .EXCEPT_PC(32'hBFC00380),
                .FLUSH_CYC(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .ext_int(ext_int), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .instr_validM(instr_validM), .pcM(pcM),
    .is_in_delayslotM(is_in_delayslotM), .src_vecM(src_vecM), .is_eretM(is_eretM),
    .redirect_ready(redirect_ready), .busy(b3_busy), .flush(b3_flush),
    .except_valid(b3_valid), .except_type(b3_type), .except_pc(b3_pc),
    .epc_we(b3_epc_we), .epc_data(b3_epc_data), .cause_bd(b3_bd));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model for dut. cyc labels the interval after each rising edge.
  // An event sampled at an edge starts at interval m_t0. Flush covers offsets
  // 0..FC-1, and the redirect runs from offset FC until ready is sampled high.
  // ---------------------------------------------------------------------------
  int          cyc;
  int          m_t0;
  logic        m_busy, m_bd, m_eret;
  logic [31:0] m_type, m_pc, m_epc;
  logic [5:0]  hist [2];   // ext_int seen at the last two edges, [0] newest

  function automatic logic model_int(input logic [5:0] s);
    logic [7:0] v;
    v = {s, cp0_cause[9:8]};
    return ((cp0_status[15:8] & v) != 8'h0) && !cp0_status[1] && cp0_status[0];
  endfunction

  function automatic logic [31:0] model_code(input logic irq);
    if (irq) return 32'h0;
    for (int i = 0; i < 8; i++) if (src_vecM[i]) return {27'b0, CODES[5*i +: 5]};
    return 32'he;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= 0; m_t0 <= 0; m_busy <= 1'b0;
      m_type <= '0; m_pc <= '0; m_epc <= '0; m_bd <= 1'b0; m_eret <= 1'b0;
      hist[0] <= '0; hist[1] <= '0;
    end else begin
      cyc     <= cyc + 1;
      hist[0] <= ext_int;
      hist[1] <= hist[0];
      if (m_busy) begin
        if (cyc - m_t0 >= FC && redirect_ready) m_busy <= 1'b0;
      end else if (instr_validM && (model_int(hist[1]) || src_vecM != 8'h0 || is_eretM)) begin
        m_busy <= 1'b1;
        m_t0   <= cyc + 1;
        m_type <= model_code(model_int(hist[1]));
        m_eret <= !model_int(hist[1]) && src_vecM == 8'h0;
        m_pc   <= (!model_int(hist[1]) && src_vecM == 8'h0) ? cp0_epc : 32'hBFC00380;
        m_epc  <= pcM - (is_in_delayslotM ? 32'd4 : 32'd0);
        m_bd   <= is_in_delayslotM;
      end
    end
  end

  int   off;
  logic e_flush, e_valid, e_we;
  always @(negedge clk) begin
    off     = cyc - m_t0;
    e_flush = m_busy && off < FC;
    e_valid = m_busy && off >= FC;
    e_we    = m_busy && off == 0 && !m_eret;
    check("m_busy",  busy, m_busy);
    check("m_flush", flush, e_flush);
    check("m_valid", except_valid, e_valid);
    check("m_type",  except_type, e_valid ? m_type : 32'hffff_ffff);
    check("m_pc",    except_pc, e_valid ? m_pc : 32'h0);
    check("m_epc_we", epc_we, e_we);
    if (e_we) begin
      check("m_epc_data", epc_data, m_epc);
      check("m_cause_bd", cause_bd, m_bd);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    instr_validM = 1'b0; src_vecM = '0; is_eretM = 1'b0; is_in_delayslotM = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || b3_busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n, vcnt;
    rst = 1'b0; ext_int = '0; cp0_status = 32'h0000_0401; cp0_cause = '0; cp0_epc = '0;
    pcM = '0; redirect_ready = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_type", except_type, 32'hffff_ffff);
    check("rst_pc", except_pc, 32'h0);
    check("rst_b3_type", b3_type, 32'hffff_ffff);

    // First event taken on the first edge after reset release.
    instr_validM = 1'b1; src_vecM = 8'b0000_0100; pcM = 32'h8000_0040;
    #2 rst = 1'b1;
    @(negedge clk);
    check("first_busy", busy, 1);
    check("first_flush", flush, 1);
    check("first_epc", epc_data, 32'h8000_0040);
    check("first_b3_flush", b3_flush, 1);
    idle_inputs();
    @(negedge clk);
    check("first_type", except_type, 32'h6);
    wait_idle();

    // Interrupt path through the synchronizer.
    ext_int = 6'b000001; instr_validM = 1'b1; pcM = 32'h8000_0100;
    @(negedge clk); @(negedge clk);
    check("irq_sync_busy", busy, 0);
    @(negedge clk);
    check("irq_flush", flush, 1);
    check("irq_we", epc_we, 1);
    check("irq_epc", epc_data, 32'h8000_0100);
    ext_int = '0; idle_inputs();
    @(negedge clk);
    check("irq_valid", except_valid, 1);
    check("irq_type", except_type, 32'h0);
    check("irq_pc", except_pc, 32'hBFC00380);
    wait_idle();
    repeat (3) @(negedge clk);

    // Simultaneous events, delay slot.
    src_vecM = 8'b0000_1001; is_eretM = 1'b1; is_in_delayslotM = 1'b1;
    pcM = 32'h8000_0008; instr_validM = 1'b1;
    @(negedge clk);
    check("sim_we", epc_we, 1);
    check("sim_epc", epc_data, 32'h8000_0004);
    check("sim_bd", cause_bd, 1);
    idle_inputs();
    @(negedge clk);
    check("sim_type", except_type, 32'h4);
    wait_idle();

    // ERET.
    is_eretM = 1'b1; cp0_epc = 32'h8000_1234; instr_validM = 1'b1; pcM = 32'h8000_0200;
    @(negedge clk);
    check("eret_flush", flush, 1);
    check("eret_no_we", epc_we, 0);
    idle_inputs(); cp0_epc = 32'h0;
    @(negedge clk);
    check("eret_pc", except_pc, 32'h8000_1234);
    check("eret_type", except_type, 32'he);
    wait_idle();

    // Backpressure. A new source event during the redirect is ignored.
    redirect_ready = 1'b0; src_vecM = 8'b0000_0010; instr_validM = 1'b1; pcM = 32'h8000_0300;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (!except_valid && n < 10) begin @(negedge clk); n++; end
    check("bp_reach_valid", except_valid, 1);
    vcnt = 0;
    while (except_valid && vcnt < 20) begin
      vcnt++;
      check("bp_type", except_type, 32'h5);
      check("bp_pc", except_pc, 32'hBFC00380);
      if (vcnt == 1) begin src_vecM = 8'b0001_0000; instr_validM = 1'b1; end
      if (vcnt == 6) begin redirect_ready = 1'b1; idle_inputs(); end
      @(negedge clk);
    end
    check("bp_valid_cycles", vcnt, 6);
    redirect_ready = 1'b1; idle_inputs();
    wait_idle();

    // EXL masking.
    cp0_status = 32'h0000_0403; ext_int = 6'b000001; instr_validM = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("exl_busy", busy, 0);
    end
    ext_int = '0; idle_inputs();
    repeat (4) @(negedge clk);
    cp0_status = 32'h0000_0401;

    // Mid-flush reset on the 3-cycle-flush instance.
    src_vecM = 8'b1000_0000; instr_validM = 1'b1; pcM = 32'h8000_0400;
    @(negedge clk);
    check("mr_b3_flush1", b3_flush, 1);
    check("mr_b3_we1", b3_epc_we, 1);
    idle_inputs();
    @(negedge clk);
    check("mr_b3_flush2", b3_flush, 1);
    check("mr_b3_we2", b3_epc_we, 0);
    #2 rst = 1'b0;
    #1;
    check("mr_b3_busy", b3_busy, 0);
    check("mr_b3_flush", b3_flush, 0);
    check("mr_b3_valid", b3_valid, 0);
    check("mr_b3_type", b3_type, 32'hffff_ffff);
    check("mr_b3_pc", b3_pc, 32'h0);
    check("mr_busy", busy, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("mr_post_valid", b3_valid, 0);
      check("mr_post_flush", b3_flush, 0);
      check("mr_post_we", b3_epc_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
